// File: rtl/br_pkg.sv
// Shared definitions for the branch predictor: the 2-bit counter type,
// the branch condition codes and the saturating counter step.
package br_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } counterT;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Saturating step: ST holds on taken, SNT holds on not-taken.
  function automatic counterT stepCounter(input counterT cur, input logic taken);
    case (cur)
      SNT:     stepCounter = taken ? WNT : SNT;
      WNT:     stepCounter = taken ? WT  : SNT;
      WT:      stepCounter = taken ? ST  : WNT;
      ST:      stepCounter = taken ? ST  : WT;
      default: stepCounter = WNT;
    endcase
  endfunction

endpackage

// File: rtl/br_resolve.sv
// Execute-stage outcome of a conditional branch or unconditional jump.
module br_resolve
  import br_pkg::*;
(
  input  logic       BranchE,
  input  logic       JumpE,
  input  logic [2:0] funct3E,
  input  logic       ZeroE,
  input  logic       ALUResultEb0,
  output logic       ActTakenE
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    ActTakenE = 1'b0;
    if (BranchE) begin
      case (funct3E)
        F3_BEQ:            ActTakenE = ZeroE;
        F3_BNE:            ActTakenE = ~ZeroE;
        F3_BLT,  F3_BLTU:  ActTakenE = ALUResultEb0;
        F3_BGE,  F3_BGEU:  ActTakenE = ~ALUResultEb0;
        default:           ActTakenE = 1'b0;
      endcase
    end else if (JumpE) begin
      ActTakenE = 1'b1;
    end
  end

endmodule

// File: rtl/br_pred.sv
// Direct-mapped branch target buffer with 2-bit counters, looked up at fetch
// and trained at execute, plus branch/mispredict performance counters.
module br_pred
  import br_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [2:0]      funct3E,
  input  logic            ZeroE,
  input  logic            ALUResultEb0,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  input  logic            StallE,
  output logic            ActTakenE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BranchCnt,
  output logic [31:0]     MispredCnt
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  logic            validQ  [ENTRIES];
  logic [TAGW-1:0] tagQ    [ENTRIES];
  logic [XLEN-1:0] targetQ [ENTRIES];
  counterT         ctrQ    [ENTRIES];

  logic [IDXW-1:0] fIdx, eIdx;
  logic [TAGW-1:0] fTag, eTag;
  logic            fHit, eHit;
  logic            resolveValid, wrTarget;
  logic            unusedPcBits;

  assign fIdx = PCF[IDXW+1:2];
  assign fTag = PCF[XLEN-1:IDXW+2];
  assign eIdx = PCE[IDXW+1:2];
  assign eTag = PCE[XLEN-1:IDXW+2];
  assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup reads the stored state only; an execute write lands next cycle.
  assign fHit        = ~reset & validQ[fIdx] & (tagQ[fIdx] == fTag);
  assign PredTakenF  = fHit & (ctrQ[fIdx] >= WT);
  assign PredTargetF = fHit ? targetQ[fIdx] : PCF + XLEN'(4);

  br_resolve uResolve (
    .BranchE      (BranchE),
    .JumpE        (JumpE),
    .funct3E      (funct3E),
    .ZeroE        (ZeroE),
    .ALUResultEb0 (ALUResultEb0),
    .ActTakenE    (ActTakenE)
  );

  assign resolveValid = (BranchE | JumpE) & ~StallE;
  assign eHit         = validQ[eIdx] & (tagQ[eIdx] == eTag);
  assign MispredictE  = resolveValid &
                        ((ActTakenE != PredTakenE) |
                         (ActTakenE & PredTakenE & (PredTargetE != PCTargetE)));
  assign RedirectPCE  = ActTakenE ? PCTargetE : PCE + XLEN'(4);

  // Target is written on allocation, on a jump, and on any taken hit.
  assign wrTarget = resolveValid & ~reset & (~BranchE | ~eHit | ActTakenE);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        ctrQ[i]   <= WNT;
      end
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else if (resolveValid) begin
      validQ[eIdx] <= 1'b1;
      if (BranchE)
        ctrQ[eIdx] <= eHit ? stepCounter(ctrQ[eIdx], ActTakenE) : (ActTakenE ? WT : WNT);
      else
        ctrQ[eIdx] <= ST;
      if (BranchCnt != '1)
        BranchCnt <= BranchCnt + 32'd1;
      if (MispredictE && (MispredCnt != '1))
        MispredCnt <= MispredCnt + 32'd1;
    end
  end

  // NOTE: tag and target arrays carry no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (wrTarget) begin
      tagQ[eIdx]    <= eTag;
      targetQ[eIdx] <= PCTargetE;
    end
  end

endmodule

// File: doc/br_pred.md
BR_PRED -- requirements
Module: br_pred

Interface
REQ-001 Parameter ENTRIES, default 64, number of predictor entries; SHALL be a power of two, 2 to 1024.
REQ-002 Parameter XLEN, default 32, address/data width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 PCF  in  XLEN  fetch-stage PC, looked up every cycle.
REQ-006 PredTakenF  out  1  fetch prediction: redirect to PredTargetF.
REQ-007 PredTargetF  out  XLEN  predicted target for PCF.
REQ-008 BranchE, JumpE  in  1 each  execute-stage conditional branch / unconditional jump.
REQ-009 funct3E  in  3  branch condition code.
REQ-010 ZeroE, ALUResultEb0  in  1 each  ALU zero flag and compare result bit 0.
REQ-011 PCE, PCTargetE  in  XLEN each  execute-stage PC and computed target.
REQ-012 PredTakenE, PredTargetE  in  1 / XLEN  prediction made for this instruction, carried down the pipeline.
REQ-013 StallE  in  1  execute stage held; SHALL block table and counter updates.
REQ-014 ActTakenE  out  1  resolved branch/jump outcome.
REQ-015 MispredictE  out  1  flush-and-redirect request.
REQ-016 RedirectPCE  out  XLEN  correct next PC when MispredictE=1.
REQ-017 BranchCnt, MispredCnt  out  32 each  performance counters.

Function
REQ-018 Index = PC[log2(ENTRIES)+1:2]; tag = PC[XLEN-1:log2(ENTRIES)+2].
REQ-019 Each entry SHALL hold valid, tag, target (XLEN) and a 2-bit counter: SNT=0, WNT=1, WT=2, ST=3.
REQ-020 PredTakenF SHALL be combinational: entry valid, tag match, and counter >= WT; else 0. PredTargetF = entry target when hit, else PCF+4.
REQ-021 With BranchE=1, ActTakenE SHALL be: funct3 000 ZeroE; 001 ~ZeroE; 100/110 ALUResultEb0; 101/111 ~ALUResultEb0; any other code 0.
REQ-022 With JumpE=1 and BranchE=0, ActTakenE=1; with neither asserted, ActTakenE=0. BranchE takes priority if both are asserted.
REQ-023 Resolve valid = (BranchE|JumpE) & ~StallE; MispredictE SHALL be 0 when resolve is not valid.
REQ-024 MispredictE = (ActTakenE != PredTakenE) | (ActTakenE & PredTakenE & (PredTargetE != PCTargetE)).
REQ-025 RedirectPCE = PCTargetE if ActTakenE, else PCE+4; width-wrapped modulo 2^XLEN.
REQ-026 On the edge after a valid branch resolve: if tag hits, counter saturating +1 when taken, -1 when not taken (ST and SNT hold); on a miss, the entry is allocated (valid=1, tag, target=PCTargetE, counter = WT if taken else WNT).
REQ-027 A not-taken branch that misses SHALL still allocate, so that aliasing replacement is deterministic.
REQ-028 On a valid jump resolve, the entry SHALL be written valid with counter=ST and target=PCTargetE.
REQ-029 A taken hit SHALL also rewrite the target with PCTargetE.
REQ-030 A same-cycle fetch read and execute write to one index SHALL return the pre-write contents (no bypass); the update is visible one cycle later.
REQ-031 BranchCnt SHALL increment on each valid resolve; MispredCnt SHALL increment when MispredictE=1. Both saturate at 2^32-1.

Reset
REQ-032 Reset SHALL clear all valid bits, set all counters to WNT, and zero BranchCnt and MispredCnt.
REQ-033 Tags and targets need not be reset.
REQ-034 While reset is high, PredTakenF=0, PredTargetF=PCF+4 and no update occurs; a resolve coincident with reset SHALL be discarded.
REQ-035 Comb outputs ActTakenE, MispredictE and RedirectPCE follow their inputs during reset.

Structure
REQ-036 Package br_pkg SHALL hold the funct3 branch-code constants and the 2-bit counter enum (SNT, WNT, WT, ST).
REQ-037 Sub-module br_resolve SHALL hold the pure combinational outcome logic of REQ-021/022.
REQ-038 The table SHALL be flop-based, because reset clearing is required.

Verification
REQ-039 After reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104; both counters read 0.
REQ-040 beq at PCE=0x100, ZeroE=1, PredTakenE=0, PCTargetE=0x200 -> ActTakenE=1, MispredictE=1, RedirectPCE=0x200. Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x200.
REQ-041 Resolve the same beq taken three times, then not taken once -> counter WT->ST->ST->WT; PredTakenF stays 1.
REQ-042 bge, ALUResultEb0=1, PredTakenE=1 -> ActTakenE=0, RedirectPCE=PCE+4, MispredictE=1. funct3=010 with BranchE=1 -> ActTakenE=0.
REQ-043 jal at 0x100 allocated, then PCE=0x200 (same index, different tag) resolves taken -> 0x100 lookup misses, 0x200 hits with counter=ST.
REQ-044 Resolve with StallE=1 -> no table change, counters unchanged, MispredictE=0. Reset asserted mid-run -> all lookups miss on the next cycle.
